axi_lite_arbiter: RTL
=====================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all AW/AR channels.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_axi_awvalid/awaddr in, s_axi_awready out  [1:0] / [1:0][ADDR_WIDTH-1:0] / [1:0]  per-port write address; bit i = port i.
REQ-005 s_axi_wvalid/wdata/wstrb in, s_axi_wready out  [1:0] / [1:0][31:0] / [1:0][3:0] / [1:0]  per-port write data.
REQ-006 s_axi_bvalid/bresp out, s_axi_bready in  [1:0] / [1:0][1:0] / [1:0]  per-port write response.
REQ-007 s_axi_arvalid/araddr in, s_axi_arready out  [1:0] / [1:0][ADDR_WIDTH-1:0] / [1:0]  per-port read address.
REQ-008 s_axi_rvalid/rdata/rresp out, s_axi_rready in  [1:0] / [1:0][31:0] / [1:0][1:0] / [1:0]  per-port read data.
REQ-009 m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  single AXI-lite master port, same signal set and widths as one slave port, directions inverted.

Function
REQ-010 Read and write paths SHALL be arbitrated independently; a read by one port and a write by the other proceed concurrently.
REQ-011 Each path SHALL have at most one transaction outstanding on the master port.
REQ-012 Write FSM SHALL be W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
REQ-013 W_IDLE: request_i = s_axi_awvalid[i]; on any request, latch wgnt and go to W_XFER next cycle (grant latency 1 cycle); no ready asserted in W_IDLE.
REQ-014 W_XFER: m_awvalid = s_awvalid[wgnt] & ~aw_done, s_awready[wgnt] = m_awready & ~aw_done; W channel identical using w_done; AW and W handshakes may complete in either order or the same cycle; go to W_RESP when both are done.
REQ-015 W_RESP: s_bvalid[wgnt] = m_bvalid, s_bresp[wgnt] = m_bresp, m_bready = s_bready[wgnt]; on m_bvalid & m_bready, go to W_IDLE and set last_wgnt = wgnt.
REQ-016 Read FSM SHALL be R_IDLE -> R_ADDR -> R_DATA -> R_IDLE, with request = s_axi_arvalid, AR forwarded in R_ADDR and R forwarded in R_DATA, mirroring REQ-013..015 (last_rgnt).
REQ-017 Arbitration: a single requester SHALL win; with both requesting, the port != last grant SHALL win (round-robin, no starvation).
REQ-018 Non-granted port: all ready/valid outputs to it SHALL be 0; its inputs are ignored.
REQ-019 Master addr/data/strb outputs SHALL mux from the granted port; they SHALL be 0 while the path is idle.
REQ-020 Response codes (bresp/rresp) SHALL pass through unmodified, including SLVERR/DECERR.
REQ-021 A request deasserted before grant SHALL be ignored; a port that remains requesting is re-arbitrated on return to idle (one idle cycle between transactions).

Reset
REQ-022 Reset SHALL force both FSMs to idle, clear aw_done/w_done, set last_wgnt = last_rgnt = 1 (port 0 wins first tie), and drive every valid/ready/addr/data output to 0 from the next cycle.
REQ-023 Reset mid-transaction SHALL abandon the transaction without completing any handshake; the downstream slave shares the same reset.

Structure
REQ-024 Package axi_lite_arb_pkg SHALL hold the write/read state enums and NUM_PORTS = 2.
REQ-025 Sub-module rr_arbiter2 (2 requests, last-grant input, one-hot grant output, combinational) SHALL be instantiated once per path.

Verification
REQ-026 Port0 write addr 0x10, data 0xDEADBEEF, strb 0xF, slave ready immediately, bresp 0 -> m_awaddr=0x10, m_wdata=0xDEADBEEF, s_bvalid[0]=1, s_axi_*ready[1] stay 0.
REQ-027 Both ports awvalid continuously for 4 writes after reset -> grant order 0,1,0,1.
REQ-028 Slave accepts AW at cycle N, holds wready until N+3 -> FSM stays in W_XFER, m_awvalid=0 after N, no B forwarded before W completes.
REQ-029 Port0 write and port1 read (araddr 0x20, rresp 2'b10) issued the same cycle -> both granted the next cycle; s_rresp[1]=2'b10, s_rdata[1]=m_rdata.
REQ-030 Reset asserted in W_RESP with m_bvalid=1 -> next cycle all outputs 0, FSM W_IDLE; both ports then requesting -> port0 granted.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types for the two-port AXI-lite arbiter: path state encodings and port count.
package axi_lite_arb_pkg;

   localparam int NUM_PORTS = 2;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_XFER = 2'd1,
      W_RESP = 2'd2
   } wstate_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rstate_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: a lone requester wins; on a tie the port
// that did not win last time is granted. Purely combinational, one-hot out.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = i_req;
      if (&i_req) o_gnt = i_last ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-port to one-port AXI-lite arbiter. Read and write paths are arbitrated
// independently, each with a single transaction outstanding on the master side.
module axi_lite_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  reset,
   // slave ports (upstream masters)
   input  logic [NUM_PORTS-1:0]                  s_axi_awvalid,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_axi_awaddr,
   output logic [NUM_PORTS-1:0]                  s_axi_awready,
   input  logic [NUM_PORTS-1:0]                  s_axi_wvalid,
   input  logic [NUM_PORTS-1:0][31:0]            s_axi_wdata,
   input  logic [NUM_PORTS-1:0][3:0]             s_axi_wstrb,
   output logic [NUM_PORTS-1:0]                  s_axi_wready,
   output logic [NUM_PORTS-1:0]                  s_axi_bvalid,
   output logic [NUM_PORTS-1:0][1:0]             s_axi_bresp,
   input  logic [NUM_PORTS-1:0]                  s_axi_bready,
   input  logic [NUM_PORTS-1:0]                  s_axi_arvalid,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_axi_araddr,
   output logic [NUM_PORTS-1:0]                  s_axi_arready,
   output logic [NUM_PORTS-1:0]                  s_axi_rvalid,
   output logic [NUM_PORTS-1:0][31:0]            s_axi_rdata,
   output logic [NUM_PORTS-1:0][1:0]             s_axi_rresp,
   input  logic [NUM_PORTS-1:0]                  s_axi_rready,
   // master port (downstream slave)
   output logic                                  m_axi_awvalid,
   output logic [ADDR_WIDTH-1:0]                 m_axi_awaddr,
   input  logic                                  m_axi_awready,
   output logic                                  m_axi_wvalid,
   output logic [31:0]                           m_axi_wdata,
   output logic [3:0]                            m_axi_wstrb,
   input  logic                                  m_axi_wready,
   input  logic                                  m_axi_bvalid,
   input  logic [1:0]                            m_axi_bresp,
   output logic                                  m_axi_bready,
   output logic                                  m_axi_arvalid,
   output logic [ADDR_WIDTH-1:0]                 m_axi_araddr,
   input  logic                                  m_axi_arready,
   input  logic                                  m_axi_rvalid,
   input  logic [31:0]                           m_axi_rdata,
   input  logic [1:0]                            m_axi_rresp,
   output logic                                  m_axi_rready
);

   wstate_e    r_wstate, w_wstate_nxt;
   logic       r_wgnt, w_wgnt_nxt;
   logic       r_last_wgnt, w_last_wgnt_nxt;
   logic       r_aw_done, w_aw_done_nxt;
   logic       r_w_done, w_w_done_nxt;
   logic [1:0] w_wgnt_oh;

   rstate_e    r_rstate, w_rstate_nxt;
   logic       r_rgnt, w_rgnt_nxt;
   logic       r_last_rgnt, w_last_rgnt_nxt;
   logic [1:0] w_rgnt_oh;

   rr_arbiter2 u_warb (
      .i_req  (s_axi_awvalid),
      .i_last (r_last_wgnt),
      .o_gnt  (w_wgnt_oh)
   );

   rr_arbiter2 u_rarb (
      .i_req  (s_axi_arvalid),
      .i_last (r_last_rgnt),
      .o_gnt  (w_rgnt_oh)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wstate    <= W_IDLE;
         r_wgnt      <= 1'b0;
         r_last_wgnt <= 1'b1;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rstate    <= R_IDLE;
         r_rgnt      <= 1'b0;
         r_last_rgnt <= 1'b1;
      end else begin
         r_wstate    <= w_wstate_nxt;
         r_wgnt      <= w_wgnt_nxt;
         r_last_wgnt <= w_last_wgnt_nxt;
         r_aw_done   <= w_aw_done_nxt;
         r_w_done    <= w_w_done_nxt;
         r_rstate    <= w_rstate_nxt;
         r_rgnt      <= w_rgnt_nxt;
         r_last_rgnt <= w_last_rgnt_nxt;
      end
   end

   // Write path: AW and W may complete in either order; B forwarded only after both.
   always_comb begin
      w_wstate_nxt    = r_wstate;
      w_wgnt_nxt      = r_wgnt;
      w_last_wgnt_nxt = r_last_wgnt;
      w_aw_done_nxt   = r_aw_done;
      w_w_done_nxt    = r_w_done;
      s_axi_awready   = '0;
      s_axi_wready    = '0;
      s_axi_bvalid    = '0;
      s_axi_bresp     = '0;
      m_axi_awvalid   = 1'b0;
      m_axi_awaddr    = '0;
      m_axi_wvalid    = 1'b0;
      m_axi_wdata     = '0;
      m_axi_wstrb     = '0;
      m_axi_bready    = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            if (|s_axi_awvalid) begin
               w_wgnt_nxt   = w_wgnt_oh[1];
               w_wstate_nxt = W_XFER;
            end
         end
         W_XFER: begin
            m_axi_awaddr          = s_axi_awaddr[r_wgnt];
            m_axi_wdata           = s_axi_wdata[r_wgnt];
            m_axi_wstrb           = s_axi_wstrb[r_wgnt];
            m_axi_awvalid         = s_axi_awvalid[r_wgnt] & ~r_aw_done;
            s_axi_awready[r_wgnt] = m_axi_awready & ~r_aw_done;
            m_axi_wvalid          = s_axi_wvalid[r_wgnt] & ~r_w_done;
            s_axi_wready[r_wgnt]  = m_axi_wready & ~r_w_done;
            if (s_axi_awvalid[r_wgnt] & m_axi_awready) w_aw_done_nxt = 1'b1;
            if (s_axi_wvalid[r_wgnt] & m_axi_wready)   w_w_done_nxt  = 1'b1;
            if (w_aw_done_nxt & w_w_done_nxt) w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            m_axi_awaddr         = s_axi_awaddr[r_wgnt];
            m_axi_wdata          = s_axi_wdata[r_wgnt];
            m_axi_wstrb          = s_axi_wstrb[r_wgnt];
            s_axi_bvalid[r_wgnt] = m_axi_bvalid;
            s_axi_bresp[r_wgnt]  = m_axi_bresp;
            m_axi_bready         = s_axi_bready[r_wgnt];
            if (m_axi_bvalid & s_axi_bready[r_wgnt]) begin
               w_wstate_nxt    = W_IDLE;
               w_last_wgnt_nxt = r_wgnt;
               w_aw_done_nxt   = 1'b0;
               w_w_done_nxt    = 1'b0;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt    = r_rstate;
      w_rgnt_nxt      = r_rgnt;
      w_last_rgnt_nxt = r_last_rgnt;
      s_axi_arready   = '0;
      s_axi_rvalid    = '0;
      s_axi_rdata     = '0;
      s_axi_rresp     = '0;
      m_axi_arvalid   = 1'b0;
      m_axi_araddr    = '0;
      m_axi_rready    = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (|s_axi_arvalid) begin
               w_rgnt_nxt   = w_rgnt_oh[1];
               w_rstate_nxt = R_ADDR;
            end
         end
         R_ADDR: begin
            m_axi_araddr          = s_axi_araddr[r_rgnt];
            m_axi_arvalid         = s_axi_arvalid[r_rgnt];
            s_axi_arready[r_rgnt] = m_axi_arready;
            if (s_axi_arvalid[r_rgnt] & m_axi_arready) w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            m_axi_araddr         = s_axi_araddr[r_rgnt];
            s_axi_rvalid[r_rgnt] = m_axi_rvalid;
            s_axi_rdata[r_rgnt]  = m_axi_rdata;
            s_axi_rresp[r_rgnt]  = m_axi_rresp;
            m_axi_rready         = s_axi_rready[r_rgnt];
            if (m_axi_rvalid & s_axi_rready[r_rgnt]) begin
               w_rstate_nxt    = R_IDLE;
               w_last_rgnt_nxt = r_rgnt;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

endmodule
